// File: rtl/dll_tlp_tx.sv
// Data-link-layer TLP transmitter: assigns sequence numbers, keeps a retry
// buffer, purges it on ACK/NAK and replays outstanding TLPs on NAK or timeout.
module dll_tlp_tx #(
  parameter int RB_DEPTH       = 8,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic         sclk,
  input  logic         srst,
  input  logic [1:0]   dlcm_state_i,
  input  logic         tl2dll_valid_i,
  input  logic [255:0] tl2dll_data_i,
  output logic         tl2dll_ready_o,
  input  logic [15:0]  acknak_seq_num_i,
  input  logic [1:0]   acknak_seq_en_i,
  input  logic         arb_ready_i,
  output logic         tlp_valid_o,
  output logic [255:0] tlp_data_o,
  output logic [11:0]  tlp_seq_o,
  output logic [11:0]  next_tx_seq_o,
  output logic         replay_active_o,
  output logic [1:0]   replay_num_o,
  output logic         retrain_req_o
);

  localparam int IDX_W = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
  localparam int TMR_W = $clog2(REPLAY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    REPLAY_WAIT = 2'd1,
    REPLAY      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        nts_q, as_q, rp_q, rp_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
  logic [1:0]         replay_num_d, replay_num_base;
  logic               retrain_d;
  logic [255:0]       rb_mem [RB_DEPTH];

  logic        link_up, out_free, full, accept;
  logic        ack_ev, nak_ev, fwd, expire, enter_wait, replay_load;
  logic [11:0] oc, oc_post, ack_seq, ack_ofs, as_new, rp_eff, rp_dist, ack_dist;
  logic        unused_seq_bits;

  assign unused_seq_bits = ^acknak_seq_num_i[15:12];

  assign link_up  = (dlcm_state_i == 2'd3);
  assign oc       = nts_q - as_q - 12'd1;
  assign full     = (oc == 12'(RB_DEPTH));
  assign out_free = !tlp_valid_o || arb_ready_i;

  assign tl2dll_ready_o  = link_up && (state_q == NORMAL) && !full && out_free;
  assign accept          = tl2dll_valid_i && tl2dll_ready_o;
  assign next_tx_seq_o   = nts_q;
  assign replay_active_o = (state_q != NORMAL);

  // A purge is accepted only when S lies in [AS+1 .. NTS-1], i.e. S-AS-1 < OC.
  assign ack_ev  = |acknak_seq_en_i;
  assign nak_ev  = acknak_seq_en_i[1];
  assign ack_seq = acknak_seq_num_i[11:0];
  assign ack_ofs = ack_seq - as_q - 12'd1;
  assign fwd     = ack_ev && (ack_ofs < oc);
  assign as_new  = fwd ? ack_seq : as_q;
  assign oc_post = nts_q - as_new - 12'd1;

  assign timer_inc = timer_q + TMR_W'(1);
  assign expire    = (state_q == NORMAL) && (oc != 12'd0) && !fwd &&
                     (timer_inc == TMR_W'(REPLAY_TIMEOUT));

  // Replay pointer skips entries an in-flight ACK has just retired.
  assign rp_dist  = rp_q - as_q;
  assign ack_dist = ack_seq - as_q;
  assign rp_eff   = (fwd && (rp_dist <= ack_dist)) ? (ack_seq + 12'd1) : rp_q;

  always_comb begin
    state_d     = state_q;
    rp_d        = rp_q;
    enter_wait  = 1'b0;
    replay_load = 1'b0;
    unique case (state_q)
      NORMAL: begin
        if ((nak_ev && (oc_post != 12'd0)) || expire) begin
          state_d    = REPLAY_WAIT;
          enter_wait = 1'b1;
        end
      end
      REPLAY_WAIT: begin
        if (out_free) begin
          state_d = REPLAY;
          rp_d    = as_new + 12'd1;
        end
      end
      REPLAY: begin
        rp_d = rp_eff;
        if (oc_post == 12'd0) begin
          state_d = NORMAL;
        end else if (out_free) begin
          replay_load = 1'b1;
          rp_d        = rp_eff + 12'd1;
          if (rp_eff == nts_q - 12'd1) state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    replay_num_base = fwd ? 2'd0 : replay_num_o;
    replay_num_d    = enter_wait ? (replay_num_base + 2'd1) : replay_num_base;
    retrain_d       = enter_wait && (replay_num_base == 2'd3);
    if ((state_q != NORMAL) || (oc == 12'd0) || fwd || expire) timer_d = '0;
    else                                                       timer_d = timer_inc;
  end

  // NOTE: the retry buffer is plain storage with no reset; every entry is
  // written before a replay can read it, so resetting it would only cost area.
  always_ff @(posedge sclk) begin
    if (accept) rb_mem[nts_q[IDX_W-1:0]] <= tl2dll_data_i;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q       <= NORMAL;
      nts_q         <= 12'd0;
      as_q          <= 12'hFFF;
      rp_q          <= 12'd0;
      timer_q       <= '0;
      replay_num_o  <= 2'd0;
      retrain_req_o <= 1'b0;
      tlp_valid_o   <= 1'b0;
      tlp_data_o    <= '0;
      tlp_seq_o     <= 12'd0;
    end else if (!link_up) begin
      state_q       <= NORMAL;
      nts_q         <= 12'd0;
      as_q          <= 12'hFFF;
      rp_q          <= 12'd0;
      timer_q       <= '0;
      replay_num_o  <= 2'd0;
      retrain_req_o <= 1'b0;
      tlp_valid_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      nts_q         <= accept ? (nts_q + 12'd1) : nts_q;
      as_q          <= as_new;
      rp_q          <= rp_d;
      timer_q       <= timer_d;
      replay_num_o  <= replay_num_d;
      retrain_req_o <= retrain_d;
      if (accept) begin
        tlp_valid_o <= 1'b1;
        tlp_data_o  <= tl2dll_data_i;
        tlp_seq_o   <= nts_q;
      end else if (replay_load) begin
        tlp_valid_o <= 1'b1;
        tlp_data_o  <= rb_mem[rp_eff[IDX_W-1:0]];
        tlp_seq_o   <= rp_eff;
      end else if (arb_ready_i) begin
        tlp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dll_tlp_tx.sv
// Directed bench for dll_tlp_tx: sequencing, back-pressure, ACK/NAK purge,
// replay, timeout/retrain, sequence wrap and link-down flush.
module tb_dll_tlp_tx;
  localparam int RB_DEPTH = 8;
  localparam int TMO      = 16;

  logic         sclk = 1'b0;
  logic         srst;
  logic [1:0]   dlcm_state_i;
  logic         tl2dll_valid_i;
  logic [255:0] tl2dll_data_i;
  logic         tl2dll_ready_o;
  logic [15:0]  acknak_seq_num_i;
  logic [1:0]   acknak_seq_en_i;
  logic         arb_ready_i;
  logic         tlp_valid_o;
  logic [255:0] tlp_data_o;
  logic [11:0]  tlp_seq_o;
  logic [11:0]  next_tx_seq_o;
  logic         replay_active_o;
  logic [1:0]   replay_num_o;
  logic         retrain_req_o;

  int checks   = 0;
  int failures = 0;

  dll_tlp_tx #(.RB_DEPTH(RB_DEPTH), .REPLAY_TIMEOUT(TMO)) dut (
    .sclk             (sclk),
    .srst             (srst),
    .dlcm_state_i     (dlcm_state_i),
    .tl2dll_valid_i   (tl2dll_valid_i),
    .tl2dll_data_i    (tl2dll_data_i),
    .tl2dll_ready_o   (tl2dll_ready_o),
    .acknak_seq_num_i (acknak_seq_num_i),
    .acknak_seq_en_i  (acknak_seq_en_i),
    .arb_ready_i      (arb_ready_i),
    .tlp_valid_o      (tlp_valid_o),
    .tlp_data_o       (tlp_data_o),
    .tlp_seq_o        (tlp_seq_o),
    .next_tx_seq_o    (next_tx_seq_o),
    .replay_active_o  (replay_active_o),
    .replay_num_o     (replay_num_o),
    .retrain_req_o    (retrain_req_o)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    dlcm_state_i = 2'd0;
    tick();
    dlcm_state_i = 2'd3;
  endtask

  task automatic send(input logic [255:0] d);
    tl2dll_valid_i = 1'b1;
    tl2dll_data_i  = d;
    tick();
    tl2dll_valid_i = 1'b0;
  endtask

  task automatic ack(input logic [1:0] en, input logic [11:0] s);
    acknak_seq_en_i  = en;
    acknak_seq_num_i = {4'd0, s};
    tick();
    acknak_seq_en_i  = 2'd0;
  endtask

  initial begin
    int  entries, bad, stable_bad;
    logic seen, prev_active;
    logic [255:0] held_data;
    logic [11:0]  held_seq;

    srst = 1'b1; dlcm_state_i = 2'd3; tl2dll_valid_i = 1'b0; tl2dll_data_i = '0;
    acknak_seq_num_i = '0; acknak_seq_en_i = 2'd0; arb_ready_i = 1'b1;
    tick(); tick();
    check("rst_valid",   tlp_valid_o, 0);
    check("rst_seq",     tlp_seq_o, 0);
    check("rst_data",    tlp_data_o, 0);
    check("rst_nts",     next_tx_seq_o, 0);
    check("rst_replay",  replay_active_o, 0);
    check("rst_rnum",    replay_num_o, 0);
    check("rst_retrain", retrain_req_o, 0);
    srst = 1'b0;
    tick();

    // Three back-to-back TLPs
    for (int i = 0; i < 3; i++) begin
      send(256'(32'hA000 + i));
      check("s1_valid", tlp_valid_o, 1);
      check("s1_seq",   tlp_seq_o, i);
      check("s1_data",  tlp_data_o, 256'(32'hA000 + i));
    end
    check("s1_nts", next_tx_seq_o, 3);
    tick();
    check("s1_drain", tlp_valid_o, 0);
    ack(2'b01, 12'd2);
    check("s1_ready_after_ack", tl2dll_ready_o, 1);

    // Fill the retry buffer, then free four entries with ACK 3
    flush();
    for (int i = 0; i < 8; i++) send(256'(32'hF000 + i));
    check("s2_full_ready", tl2dll_ready_o, 0);
    acknak_seq_en_i = 2'b01; acknak_seq_num_i = 16'd3;
    #1;
    check("s2_pre_ack_ready", tl2dll_ready_o, 0);
    tick();
    acknak_seq_en_i = 2'b00;
    check("s2_post_ack_ready", tl2dll_ready_o, 1);
    for (int i = 0; i < 4; i++) send(256'(32'hF100 + i));
    check("s2_oc4_refull", tl2dll_ready_o, 0);
    check("s2_nts", next_tx_seq_o, 12);

    // NAK 1 after sending 0..4: replay 2,3,4
    flush();
    for (int i = 0; i < 5; i++) send(256'(32'hB000 + i));
    ack(2'b10, 12'd1);
    check("s3_active",  replay_active_o, 1);
    check("s3_rnum",    replay_num_o, 1);
    check("s3_ready0",  tl2dll_ready_o, 0);
    tick();
    check("s3_wait_valid", tlp_valid_o, 0);
    check("s3_wait_ready", tl2dll_ready_o, 0);
    for (int i = 2; i < 5; i++) begin
      tick();
      check("s3_rp_valid", tlp_valid_o, 1);
      check("s3_rp_seq",   tlp_seq_o, i);
      check("s3_rp_data",  tlp_data_o, 256'(32'hB000 + i));
      if (i < 4) check("s3_rp_ready", tl2dll_ready_o, 0);
    end
    check("s3_done_active", replay_active_o, 0);
    check("s3_done_ready",  tl2dll_ready_o, 1);
    ack(2'b01, 12'd4);
    check("s3_rnum_clear", replay_num_o, 0);

    // Four timeouts without ACK: retrain on the fourth
    send(256'(32'hC005));
    entries = 0; seen = 1'b0; prev_active = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      if (replay_active_o && !prev_active) entries++;
      prev_active = replay_active_o;
      if (retrain_req_o) seen = 1'b1;
    end
    check("s4_retrain_seen", seen, 1);
    check("s4_entries",      entries, 4);
    check("s4_rnum_wrap",    replay_num_o, 0);
    tick();
    check("s4_pulse_width",  retrain_req_o, 0);
    check("s4_replay_goes",  replay_active_o, 1);
    tick();
    check("s4_replay_seq",   tlp_seq_o, 5);
    check("s4_replay_data",  tlp_data_o, 256'(32'hC005));
    ack(2'b01, 12'd5);

    // Walk NTS to 4094 with concurrent accept + ACK, then wrap
    flush();
    bad = 0;
    for (int i = 0; i < 4094; i++) begin
      tl2dll_valid_i   = 1'b1;
      tl2dll_data_i    = 256'(i);
      acknak_seq_en_i  = (i > 0) ? 2'b01 : 2'b00;
      acknak_seq_num_i = 16'(i - 1);
      #1;
      if (!tl2dll_ready_o) bad++;
      tick();
    end
    tl2dll_valid_i = 1'b0;
    ack(2'b01, 12'd4093);
    check("s5_walk_ready", bad, 0);
    check("s5_nts_4094",   next_tx_seq_o, 4094);
    for (int i = 0; i < 4; i++) begin
      send(256'(32'hE000 + i));
      check("s5_wrap_seq", tlp_seq_o, (4094 + i) % 4096);
    end
    check("s5_nts_2", next_tx_seq_o, 2);
    ack(2'b01, 12'd0);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tl2dll_valid_i = 1'b1;
      #1;
      if (!tl2dll_ready_o) bad++;
      tick();
    end
    tl2dll_valid_i = 1'b0;
    check("s5_oc1_room",  bad, 0);
    check("s5_oc1_full",  tl2dll_ready_o, 0);
    ack(2'b01, 12'd100);
    check("s5_out_of_range", tl2dll_ready_o, 0);
    ack(2'b01, 12'd0);
    check("s5_same_as_noop", tl2dll_ready_o, 0);
    ack(2'b01, 12'd8);
    check("s5_ack8_ready", tl2dll_ready_o, 1);
    check("s5_nts_9",      next_tx_seq_o, 9);

    // Arbiter stall holds the output; link-down flushes
    arb_ready_i = 1'b0;
    send(256'(32'hD009));
    check("s6_valid", tlp_valid_o, 1);
    check("s6_seq",   tlp_seq_o, 9);
    check("s6_ready", tl2dll_ready_o, 0);
    held_data = tlp_data_o; held_seq = tlp_seq_o; stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!tlp_valid_o || tlp_seq_o !== held_seq || tlp_data_o !== held_data) stable_bad++;
    end
    check("s6_stable", stable_bad, 0);
    check("s6_data",   tlp_data_o, 256'(32'hD009));
    flush();
    check("s6_flush_valid", tlp_valid_o, 0);
    check("s6_flush_nts",   next_tx_seq_o, 0);
    arb_ready_i = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
